// File: rtl/ofm_in_fsm.sv
// Transmit-side frame sequencer: walks the MM2S control-word stream, forwards frame
// data to the TX data FIFO and emits one checksum/byte-count info word per good frame.
module ofm_in_fsm (
    input  logic        mm2s_clk,
    input  logic        mm2s_resetn,
    input  logic [36:0] ctrl_fifo_rdata,
    input  logic        ctrl_fifo_empty,
    output logic        ctrl_fifo_rden,
    input  logic [72:0] data_fifo_rdata,
    input  logic        data_fifo_empty,
    output logic        data_fifo_rden,
    output logic [72:0] tx_fifo_wdata,
    output logic        tx_fifo_wren,
    input  logic        tx_fifo_afull,
    output logic [64:0] info_fifo_wdata,
    output logic        info_fifo_wren,
    input  logic        info_fifo_afull,
    output logic [3:0]  ofm_in_fsm_dbg
);
    localparam int C_INFO_W = 65;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CTRL = 3'd1,
        S_SKIP = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4,
        S_INFO = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_wcnt;
    logic          r_flag_ok;
    logic          r_csum_en;
    logic [15:0]   r_csum_begin;
    logic [15:0]   r_csum_insert;
    logic [15:0]   r_csum_init;
    logic [15:0]   r_bytecnt;

    logic [31:0]         w_ctrl_word;
    logic                w_ctrl_last;
    logic                w_data_last;
    logic                w_flag_ok;
    logic [3:0]          w_keep_cnt;
    logic [C_INFO_W-1:0] w_info_word;
    logic                w_unused_ctrl_keep;

    function automatic logic [3:0] popcnt8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, k[i]};
        return n;
    endfunction

    assign w_ctrl_word        = ctrl_fifo_rdata[31:0];
    assign w_ctrl_last        = ctrl_fifo_rdata[36];
    assign w_data_last        = data_fifo_rdata[72];
    assign w_keep_cnt         = popcnt8(data_fifo_rdata[71:64]);
    assign w_unused_ctrl_keep = &{1'b0, ctrl_fifo_rdata[35:32]};
    // A one-word control stream decides validity from the flag word being popped right now.
    assign w_flag_ok   = (r_wcnt == 3'd0) ? (w_ctrl_word[31:28] == 4'hA) : r_flag_ok;
    assign w_info_word = {r_csum_en, r_csum_begin, r_csum_insert, r_csum_init, r_bytecnt};
    assign ofm_in_fsm_dbg = {tx_fifo_afull, r_state};

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) r_state <= S_IDLE;
        else              r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (!ctrl_fifo_empty) w_state_next = S_CTRL;
            S_CTRL: if (ctrl_fifo_rden) begin
                if (w_ctrl_last)          w_state_next = w_flag_ok ? S_DATA : S_DROP;
                else if (r_wcnt == 3'd5)  w_state_next = S_SKIP;
            end
            S_SKIP: if (ctrl_fifo_rden && w_ctrl_last) w_state_next = r_flag_ok ? S_DATA : S_DROP;
            S_DATA: if (data_fifo_rden && w_data_last) w_state_next = S_INFO;
            S_DROP: if (data_fifo_rden && w_data_last) w_state_next = S_IDLE;
            S_INFO: if (!info_fifo_afull) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl_fifo_rden = 1'b0;
        data_fifo_rden = 1'b0;
        case (r_state)
            S_CTRL, S_SKIP: ctrl_fifo_rden = !ctrl_fifo_empty;
            S_DATA:         data_fifo_rden = !data_fifo_empty && !tx_fifo_afull;
            S_DROP:         data_fifo_rden = !data_fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge mm2s_clk or negedge mm2s_resetn) begin
        if (!mm2s_resetn) begin
            r_wcnt          <= 3'd0;
            r_flag_ok       <= 1'b0;
            r_csum_en       <= 1'b0;
            r_csum_begin    <= 16'd0;
            r_csum_insert   <= 16'd0;
            r_csum_init     <= 16'd0;
            r_bytecnt       <= 16'd0;
            tx_fifo_wren    <= 1'b0;
            tx_fifo_wdata   <= 73'd0;
            info_fifo_wren  <= 1'b0;
            info_fifo_wdata <= 65'd0;
        end else begin
            tx_fifo_wren   <= (r_state == S_DATA) && data_fifo_rden;
            info_fifo_wren <= (r_state == S_INFO) && !info_fifo_afull;
            if ((r_state == S_DATA) && data_fifo_rden) tx_fifo_wdata <= data_fifo_rdata;
            if ((r_state == S_INFO) && !info_fifo_afull) info_fifo_wdata <= w_info_word;
            case (r_state)
                S_IDLE: begin
                    r_wcnt        <= 3'd0;
                    r_flag_ok     <= 1'b0;
                    r_csum_en     <= 1'b0;
                    r_csum_begin  <= 16'd0;
                    r_csum_insert <= 16'd0;
                    r_csum_init   <= 16'd0;
                    r_bytecnt     <= 16'd0;
                end
                S_CTRL: if (ctrl_fifo_rden) begin
                    r_wcnt <= r_wcnt + 3'd1;
                    case (r_wcnt)
                        3'd0: r_flag_ok <= (w_ctrl_word[31:28] == 4'hA);
                        3'd1: r_csum_en <= w_ctrl_word[0];
                        3'd2: begin
                            r_csum_begin  <= w_ctrl_word[31:16];
                            r_csum_insert <= w_ctrl_word[15:0];
                        end
                        3'd3: r_csum_init <= w_ctrl_word[15:0];
                        default: ;
                    endcase
                end
                S_DATA: if (data_fifo_rden) r_bytecnt <= r_bytecnt + {12'd0, w_keep_cnt};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ofm_in_fsm.sv
// Directed bench for ofm_in_fsm: queue-backed FWFT FIFO models feed the DUT and the
// TX/info writes are compared against hand-computed expectations.
module tb_ofm_in_fsm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [36:0] ctrl_fifo_rdata = '0;
    logic        ctrl_fifo_empty = 1'b1;
    logic        ctrl_fifo_rden;
    logic [72:0] data_fifo_rdata = '0;
    logic        data_fifo_empty = 1'b1;
    logic        data_fifo_rden;
    logic [72:0] tx_fifo_wdata;
    logic        tx_fifo_wren;
    logic        tx_fifo_afull = 1'b0;
    logic [64:0] info_fifo_wdata;
    logic        info_fifo_wren;
    logic        info_fifo_afull = 1'b0;
    logic [3:0]  dbg;

    ofm_in_fsm dut (
        .mm2s_clk        (clk),
        .mm2s_resetn     (rst_n),
        .ctrl_fifo_rdata (ctrl_fifo_rdata),
        .ctrl_fifo_empty (ctrl_fifo_empty),
        .ctrl_fifo_rden  (ctrl_fifo_rden),
        .data_fifo_rdata (data_fifo_rdata),
        .data_fifo_empty (data_fifo_empty),
        .data_fifo_rden  (data_fifo_rden),
        .tx_fifo_wdata   (tx_fifo_wdata),
        .tx_fifo_wren    (tx_fifo_wren),
        .tx_fifo_afull   (tx_fifo_afull),
        .info_fifo_wdata (info_fifo_wdata),
        .info_fifo_wren  (info_fifo_wren),
        .info_fifo_afull (info_fifo_afull),
        .ofm_in_fsm_dbg  (dbg)
    );

    always #5 clk = ~clk;

    logic [36:0] ctrl_q[$];
    logic [72:0] data_q[$];
    logic [72:0] exp_tx[$];
    logic [64:0] exp_info[$];
    int checks = 0;
    int errors = 0;
    int viol = 0;
    int tx_cnt = 0;
    int info_cnt = 0;
    int data_pops = 0;
    int ctrl_pops = 0;
    logic toggle_en = 1'b0;
    logic phase = 1'b0;
    logic [63:0] seed = 64'h0123_4567_89AB_0000;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // FIFO pop side: sample the DUT's pop strobes at the edge they take effect.
    always @(posedge clk) begin
        if (ctrl_fifo_rden) begin
            if (ctrl_fifo_empty || ctrl_q.size() == 0) viol++;
            else begin
                void'(ctrl_q.pop_front());
                ctrl_pops++;
            end
        end
        if (data_fifo_rden) begin
            if (data_fifo_empty || data_q.size() == 0) viol++;
            else begin
                void'(data_q.pop_front());
                data_pops++;
            end
            if (dbg[2:0] != 3'd3 && dbg[2:0] != 3'd4) viol++;
            if (dbg[2:0] == 3'd3 && tx_fifo_afull) viol++;
        end
    end

    // FIFO present side plus write monitors, away from the active edge.
    always @(negedge clk) begin
        phase = ~phase;
        ctrl_fifo_empty = (ctrl_q.size() == 0);
        ctrl_fifo_rdata = (ctrl_q.size() != 0) ? ctrl_q[0] : 37'd0;
        data_fifo_empty = (data_q.size() == 0) || (toggle_en && phase);
        data_fifo_rdata = (data_q.size() != 0) ? data_q[0] : 73'd0;
        if (tx_fifo_wren) begin
            tx_cnt++;
            $display("tx   %h", tx_fifo_wdata);
            if (exp_tx.size() == 0) chk("tx_extra", 73'd1, 73'd0);
            else chk("tx_data", tx_fifo_wdata, exp_tx.pop_front());
        end
        if (info_fifo_wren) begin
            info_cnt++;
            $display("info %h", info_fifo_wdata);
            if (exp_info.size() == 0) chk("info_extra", 73'd1, 73'd0);
            else chk("info_data", {8'd0, info_fifo_wdata}, {8'd0, exp_info.pop_front()});
        end
    end

    task automatic push_ctrl(input logic [31:0] w, input logic last);
        ctrl_q.push_back({last, 4'hF, w});
    endtask

    task automatic push_data(input logic [7:0] keep, input logic last, input logic fwd);
        logic [72:0] b;
        seed = seed + 64'h1111_0000_0000_0011;
        b = {last, keep, seed};
        data_q.push_back(b);
        if (fwd) exp_tx.push_back(b);
    endtask

    task automatic frame_a;
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0001, 1'b0);
        push_ctrl(32'h0022_0032, 1'b0);
        push_ctrl(32'h0000_BEEF, 1'b0);
        push_ctrl(32'h0000_0000, 1'b0);
        push_ctrl(32'h0000_0000, 1'b1);
        for (int i = 0; i < 7; i++) push_data(8'hFF, 1'b0, 1'b1);
        push_data(8'h0F, 1'b1, 1'b1);
        exp_info.push_back({1'b1, 16'h0022, 16'h0032, 16'hBEEF, 16'h003C});
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(ctrl_q.size() == 0 && data_q.size() == 0 && dbg[2:0] == 3'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {72'd0, n < budget}, 73'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        int n = 0;
        @(negedge clk);
        while (dbg[2:0] != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {72'd0, n < budget}, 73'd1);
    endtask

    initial begin
        int b_tx, b_info, b_pop, b_ctrl;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_wren", {72'd0, tx_fifo_wren}, 73'd0);
        chk("rst_info_wren", {72'd0, info_fifo_wren}, 73'd0);
        chk("rst_tx_wdata", tx_fifo_wdata, 73'd0);
        chk("rst_info_wdata", {8'd0, info_fifo_wdata}, 73'd0);
        chk("rst_state", {70'd0, dbg[2:0]}, 73'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full frame with checksum fields, 60 bytes
        b_tx = tx_cnt; b_info = info_cnt;
        frame_a();
        wait_idle("t1_idle", 200);
        chk("t1_tx_cnt", 73'(tx_cnt - b_tx), 73'd8);
        chk("t1_info_cnt", 73'(info_cnt - b_info), 73'd1);

        // Invalid flag: frame dropped
        b_tx = tx_cnt; b_info = info_cnt; b_pop = data_pops;
        push_ctrl(32'h5000_0000, 1'b1);
        for (int i = 0; i < 3; i++) push_data(8'hFF, 1'b0, 1'b0);
        push_data(8'hFF, 1'b1, 1'b0);
        wait_idle("t2_idle", 100);
        chk("t2_pops", 73'(data_pops - b_pop), 73'd4);
        chk("t2_tx_cnt", 73'(tx_cnt - b_tx), 73'd0);
        chk("t2_info_cnt", 73'(info_cnt - b_info), 73'd0);
        chk("t2_state", {70'd0, dbg[2:0]}, 73'd0);

        // Short control stream, single-beat frame
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0000, 1'b1);
        push_data(8'h03, 1'b1, 1'b1);
        exp_info.push_back({1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0002});
        wait_idle("t3a_idle", 100);

        // 8-word control stream: words 6 and 7 skipped
        b_ctrl = ctrl_pops;
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0001, 1'b0);
        push_ctrl(32'h0022_0032, 1'b0);
        push_ctrl(32'h0000_BEEF, 1'b0);
        push_ctrl(32'h0000_0000, 1'b0);
        push_ctrl(32'h0000_0000, 1'b0);
        push_ctrl(32'hFFFF_FFFF, 1'b0);
        push_ctrl(32'hFFFF_FFFF, 1'b1);
        push_data(8'hFF, 1'b1, 1'b1);
        exp_info.push_back({1'b1, 16'h0022, 16'h0032, 16'hBEEF, 16'h0008});
        wait_idle("t3b_idle", 100);
        chk("t3b_ctrl_pops", 73'(ctrl_pops - b_ctrl), 73'd8);

        // Backpressure: tx afull mid-frame, info afull in S_INFO
        b_tx = tx_cnt;
        info_fifo_afull = 1'b1;
        frame_a();
        begin
            int n = 0;
            while (tx_cnt - b_tx < 3 && n < 100) begin @(negedge clk); n++; end
            chk("t4_tx_start", {72'd0, n < 100}, 73'd1);
        end
        tx_fifo_afull = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t4_rden_afull", {72'd0, data_fifo_rden}, 73'd0);
        end
        chk("t4_dbg_afull", {72'd0, dbg[3]}, 73'd1);
        tx_fifo_afull = 1'b0;
        wait_state("t4_reach_info", 3'd5, 100);
        repeat (5) begin
            @(negedge clk);
            chk("t4_info_held", {72'd0, info_fifo_wren}, 73'd0);
        end
        info_fifo_afull = 1'b0;
        @(negedge clk);
        chk("t4_info_release", {72'd0, info_fifo_wren}, 73'd1);
        wait_idle("t4_idle", 100);
        chk("t4_tx_cnt", 73'(tx_cnt - b_tx), 73'd8);

        // Data FIFO empty toggling: 8+4+1+1 = 14 bytes
        toggle_en = 1'b1;
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0000, 1'b1);
        push_data(8'hFF, 1'b0, 1'b1);
        push_data(8'h0F, 1'b0, 1'b1);
        push_data(8'h01, 1'b0, 1'b1);
        push_data(8'h80, 1'b1, 1'b1);
        exp_info.push_back({1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h000E});
        wait_idle("t5a_idle", 100);
        toggle_en = 1'b0;

        // Back-to-back frames, info in order
        b_info = info_cnt;
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0001, 1'b1);
        push_data(8'hFF, 1'b0, 1'b1);
        push_data(8'hFF, 1'b1, 1'b1);
        exp_info.push_back({1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0010});
        push_ctrl(32'hA000_0000, 1'b0);
        push_ctrl(32'h0000_0000, 1'b0);
        push_ctrl(32'h1234_5678, 1'b0);
        push_ctrl(32'h0000_CAFE, 1'b1);
        push_data(8'h3F, 1'b1, 1'b1);
        exp_info.push_back({1'b0, 16'h1234, 16'h5678, 16'hCAFE, 16'h0006});
        wait_idle("t5b_idle", 200);
        chk("t5b_info_cnt", 73'(info_cnt - b_info), 73'd2);

        // Asynchronous reset in the middle of S_DATA
        b_info = info_cnt;
        tx_fifo_afull = 1'b1;
        frame_a();
        wait_state("t6_reach_data", 3'd3, 100);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_state", {70'd0, dbg[2:0]}, 73'd0);
        chk("t6_tx_wren", {72'd0, tx_fifo_wren}, 73'd0);
        chk("t6_tx_wdata", tx_fifo_wdata, 73'd0);
        chk("t6_info_wren", {72'd0, info_fifo_wren}, 73'd0);
        chk("t6_data_rden", {72'd0, data_fifo_rden}, 73'd0);
        chk("t6_ctrl_rden", {72'd0, ctrl_fifo_rden}, 73'd0);
        ctrl_q.delete();
        data_q.delete();
        exp_tx.delete();
        exp_info.delete();
        tx_fifo_afull = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_info", 73'(info_cnt - b_info), 73'd0);
        #1 rst_n = 1'b1;
        b_tx = tx_cnt; b_info = info_cnt;
        frame_a();
        wait_idle("t6_idle", 200);
        chk("t6_tx_cnt", 73'(tx_cnt - b_tx), 73'd8);
        chk("t6_info_cnt", 73'(info_cnt - b_info), 73'd1);

        chk("proto_viol", 73'(viol), 73'd0);
        chk("exp_tx_left", 73'(exp_tx.size()), 73'd0);
        chk("exp_info_left", 73'(exp_info.size()), 73'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
